// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed MULT/DIV latencies.
// Define MDU_MADD_EN to enable the MADD (op 6) / MSUB (op 7) accumulate operations.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             launch;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b, mag_q, mag_r, sdiv_q, sdiv_r;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Results are derived from the operands latched at accept time only.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide on magnitudes; MIN / -1 falls out as MIN with zero remainder.
    assign neg_a  = a_q[WIDTH-1];
    assign neg_b  = b_q[WIDTH-1];
    assign abs_a  = neg_a ? -a_q : a_q;
    assign abs_b  = neg_b ? -b_q : b_q;
    assign mag_q  = abs_a / abs_b;
    assign mag_r  = abs_a % abs_b;
    assign sdiv_q = (neg_a ^ neg_b) ? -mag_q : mag_q;
    assign sdiv_r = neg_a ? -mag_r : mag_r;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = '1;
                end else begin
                    res_hi = sdiv_r;
                    res_lo = sdiv_q;
                end
            end
            OP_DIVU: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = '1;
                end else begin
                    res_hi = a_q % b_q;
                    res_lo = a_q / b_q;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
            OP_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU: begin
                            launch = 1'b1;
                            cnt_d  = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV, OP_DIVU: begin
                            launch = 1'b1;
                            cnt_d  = CNT_W'(DIV_CYCLES);
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MSUB: begin
                            launch = 1'b1;
                            cnt_d  = CNT_W'(MULT_CYCLES);
                        end
`endif
                        default: ;
                    endcase
                    if (launch) begin
                        state_d = S_BUSY;
                        op_d    = bus.op;
                        a_d     = bus.a;
                        b_d     = bus.b;
                    end
                end
            end
            S_BUSY: begin
                // Requests arriving here are dropped; the last busy cycle commits HI and LO together.
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == S_BUSY);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus queues expected HI/LO and completion cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mdu_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    mdu_if #(.WIDTH(W)) bus ();

    mdu_unit #(
        .WIDTH(W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one request in the current cycle; the accepting edge is the next posedge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input int lat);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + lat + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                                 input int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (bus.busy !== 1'b0) checkOutput("wait_idle", 64'(bus.busy), 64'd0);
        issue(op, a, b, push, eh, el, lat);
    endtask

    task automatic waitDone(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        checkOutput(name, 64'(bus.done), 64'd1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        checkOutput("drain_pending", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                checkOutput("result_hi", 64'(bus.hi), 64'(e.hi));
                checkOutput("result_lo", 64'(bus.lo), 64'(e.lo));
                checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_hi", 64'(bus.hi), 64'd0);
        checkOutput("rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Multiply: signed vs unsigned on the same operands, plus extremes
        applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
        checkOutput("mult_busy", 64'(bus.busy), 64'd1);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1, 32'h0000_0002, 32'hFFFF_FFFA, MC);
        applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0000_0000, MC);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, MC);

        // Divide: sign rules, overflow, divide by zero
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
        checkOutput("div_busy", 64'(bus.busy), 64'd1);
        applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1, 32'h0000_0001, 32'hFFFF_FFFD, DC);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, DC);
        applyStimulus(OP_DIVU, 32'd7, 32'd0, 1, 32'h0000_0007, 32'hFFFF_FFFF, DC);
        applyStimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DC);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 1, 32'h0000_0002, 32'h0000_000E, DC);

        // Busy rules: ignored request mid-op, late operand changes, back-to-back in done cycle
        applyStimulus(OP_MULT, 32'd6, 32'd7, 1, 32'h0000_0000, 32'h0000_002A, MC);
        bus.a = 32'hDEAD_0000;
        bus.b = 32'h0000_BEEF;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'h0000_1234;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone("mult_done_seen");
        checkOutput("done_cycle_busy", 64'(bus.busy), 64'd0);
        checkOutput("mthi_ignored_hi", 64'(bus.hi), 64'd0);
        issue(OP_DIVU, 32'd100, 32'd7, 1, 32'h0000_0002, 32'h0000_000E, DC);
        checkOutput("b2b_busy", 64'(bus.busy), 64'd1);
        bus.a = 32'd5;
        bus.b = 32'd1;
        drain();

        // MTHI then MTLO on consecutive cycles
        applyStimulus(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 0, '0, '0, 0);
        checkOutput("mthi_hi", 64'(bus.hi), 64'hA5A5_A5A5);
        checkOutput("mthi_busy", 64'(bus.busy), 64'd0);
        checkOutput("mthi_done", 64'(bus.done), 64'd0);
        applyStimulus(OP_MTLO, 32'h5A5A_5A5A, 32'd0, 0, '0, '0, 0);
        checkOutput("mtlo_lo", 64'(bus.lo), 64'h5A5A_5A5A);
        checkOutput("mtlo_hi_kept", 64'(bus.hi), 64'hA5A5_A5A5);
        checkOutput("mtlo_busy", 64'(bus.busy), 64'd0);
        checkOutput("mtlo_done", 64'(bus.done), 64'd0);

        // Accumulate ops (or their absence)
        applyStimulus(OP_MTHI, 32'h0000_0000, 32'd0, 0, '0, '0, 0);
        applyStimulus(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, '0, '0, 0);
`ifdef MDU_MADD_EN
        applyStimulus(OP_MADD, 32'd1, 32'd1, 1, 32'h0000_0001, 32'h0000_0000, MC);
        applyStimulus(OP_MSUB, 32'd1, 32'd1, 1, 32'h0000_0000, 32'hFFFF_FFFF, MC);
        drain();
`else
        applyStimulus(OP_MADD, 32'd1, 32'd1, 0, '0, '0, 0);
        checkOutput("madd_off_busy", 64'(bus.busy), 64'd0);
        applyStimulus(OP_MSUB, 32'd1, 32'd1, 0, '0, '0, 0);
        checkOutput("msub_off_busy", 64'(bus.busy), 64'd0);
        repeat (MC + 2) @(negedge clk);
        checkOutput("madd_off_hi", 64'(bus.hi), 64'h0000_0000);
        checkOutput("madd_off_lo", 64'(bus.lo), 64'hFFFF_FFFF);
`endif

        // Reset after assorted ops, then abort a DIV in its fourth busy cycle
        applyStimulus(OP_MTHI, $urandom | 32'h1, 32'd0, 0, '0, '0, 0);
        applyStimulus(OP_MTLO, $urandom | 32'h1, 32'd0, 0, '0, '0, 0);
        applyStimulus(OP_MULT, $urandom, $urandom, 0, '0, '0, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst2_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst2_done", 64'(bus.done), 64'd0);
        checkOutput("rst2_hi", 64'(bus.hi), 64'd0);
        checkOutput("rst2_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(OP_MTHI, 32'h0000_0077, 32'd0, 0, '0, '0, 0);
        applyStimulus(OP_MTLO, 32'h0000_0088, 32'd0, 0, '0, '0, 0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, '0, '0, 0);
        repeat (4) @(negedge clk);
        checkOutput("abort_pre_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_hi", 64'(bus.hi), 64'd0);
        checkOutput("abort_lo", 64'(bus.lo), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (DC + 5) @(negedge clk);
        checkOutput("abort_hi_after", 64'(bus.hi), 64'd0);
        checkOutput("abort_lo_after", 64'(bus.lo), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
